// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: in-order MSHR queue issuing one block read at a time and filling the dcache.
// Encodings: mem_command BUS_NONE=0/BUS_LOAD=1, fill_size DOUBLE=3. Define DCACHE_MISS_FAST_FILL_EN to fill in the tag-match cycle.
module dcache_miss_ctrl #(
   parameter int MSHR_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        miss_valid,
   input  logic [31:0] miss_addr,
   output logic        miss_ready,
   output logic [1:0]  mem_command,
   output logic [31:0] mem_addr,
   input  logic [3:0]  mem_response,
   input  logic [63:0] mem_data,
   input  logic [3:0]  mem_tag,
   output logic        fill_en,
   output logic [31:0] fill_addr,
   output logic [63:0] fill_data,
   output logic [1:0]  fill_size,
   output logic        busy
);
   localparam int AW = $clog2(MSHR_DEPTH);
   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;
   localparam logic [1:0] DOUBLE = 2'd3;
`ifdef DCACHE_MISS_FAST_FILL_EN
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
   logic [63:0] data_q, data_d;
`endif
   state_t state, nxt;
   logic [28:0] q [MSHR_DEPTH];
   logic [MSHR_DEPTH-1:0] vld, head_oh;
   logic [AW-1:0] head, tail;
   logic [3:0] tag_q, tag_d;
   logic [31:0] head_blk;
   logic match, full, push, pop, hit, remain;
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < MSHR_DEPTH; i++)
         if (vld[i] && q[i] == miss_addr[31:3]) match = 1'b1;
   end
   assign full = &vld;
   assign miss_ready = match | ~full;
   assign push = miss_valid & ~match & ~full;
   assign head_blk = {q[head], 3'b000};
   assign head_oh = MSHR_DEPTH'(1) << head;
   assign remain = (|(vld & ~head_oh)) | push;
   // tag_q is nonzero only in WAIT, so an idle mem_tag of 0 can never hit
   assign hit = (tag_q != 4'd0) && (mem_tag == tag_q);
   assign fill_size = DOUBLE;
   assign busy = (state != IDLE) | (|vld);
   always_comb begin
      nxt = state;
      mem_command = BUS_NONE;
      mem_addr = '0;
      fill_en = 1'b0;
      fill_addr = '0;
      fill_data = '0;
      pop = 1'b0;
      tag_d = '0;
`ifndef DCACHE_MISS_FAST_FILL_EN
      data_d = data_q;
`endif
      case (state)
         IDLE: nxt = |vld ? REQ : IDLE;
         REQ: begin
            mem_command = BUS_LOAD;
            mem_addr = head_blk;
            tag_d = mem_response;
            nxt = mem_response != 4'd0 ? WAIT : REQ;
         end
         WAIT: begin
            tag_d = hit ? 4'd0 : tag_q;
`ifdef DCACHE_MISS_FAST_FILL_EN
            fill_en = hit;
            fill_addr = hit ? head_blk : '0;
            fill_data = hit ? mem_data : '0;
            pop = hit;
            nxt = hit ? (remain ? REQ : IDLE) : WAIT;
`else
            data_d = hit ? mem_data : data_q;
            nxt = hit ? FILL : WAIT;
`endif
         end
`ifndef DCACHE_MISS_FAST_FILL_EN
         FILL: begin
            fill_en = 1'b1;
            fill_addr = head_blk;
            fill_data = data_q;
            pop = 1'b1;
            nxt = remain ? REQ : IDLE;
         end
`endif
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         vld <= '0;
         head <= '0;
         tail <= '0;
         tag_q <= '0;
`ifndef DCACHE_MISS_FAST_FILL_EN
         data_q <= '0;
`endif
      end else begin
         state <= nxt;
         tag_q <= tag_d;
`ifndef DCACHE_MISS_FAST_FILL_EN
         data_q <= data_d;
`endif
         if (push) begin
            q[tail] <= miss_addr[31:3];
            vld[tail] <= 1'b1;
            tail <= tail + 1'b1;
         end
         if (pop) begin
            vld[head] <= 1'b0;
            head <= head + 1'b1;
         end
      end
   end
endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 Parameter MSHR_DEPTH, default 4, SHALL set the number of miss-queue entries (power of two, >=2).
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset.
REQ-004 miss_valid  input  1  SHALL indicate a dcache read-miss request this cycle.
REQ-005 miss_addr  input  32  SHALL carry the missing address; bits [2:0] ignored (8-byte block).
REQ-006 miss_ready  output  1  SHALL indicate the miss is accepted this cycle (combinational).
REQ-007 mem_command  output  BUS_COMMAND  SHALL drive BUS_LOAD or BUS_NONE to memory.
REQ-008 mem_addr  output  32  SHALL carry the block-aligned request address.
REQ-009 mem_response  input  4  SHALL carry the transaction tag granted by memory; 0 means rejected.
REQ-010 mem_data  input  64  SHALL carry returned block data.
REQ-011 mem_tag  input  4  SHALL identify the transaction completing this cycle; 0 means none.
REQ-012 fill_en  output  1  SHALL drive the cache fill write-port enable.
REQ-013 fill_addr  output  DCACHE_DMAP_ADDR  SHALL carry the block-aligned fill address.
REQ-014 fill_data  output  DCACHE_BLOCK  SHALL carry the fill block.
REQ-015 fill_size  output  MEM_SIZE  SHALL be constant DOUBLE.
REQ-016 busy  output  1  SHALL be high when state != IDLE or the queue is non-empty.

Function
REQ-017 Miss queue SHALL be an in-order FIFO of MSHR_DEPTH block addresses; head is the in-flight or next request.
REQ-018 Coalesce: miss_addr[31:3] equal to any valid entry SHALL give miss_ready=1, no allocation.
REQ-019 Non-matching miss SHALL give miss_ready=!full, enqueueing at the edge when miss_valid && miss_ready.
REQ-020 Full queue SHALL hold miss_ready=0 for non-matching misses even during a pop that cycle.
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, FILL.
REQ-022 IDLE: queue non-empty -> REQ next edge; else stay.
REQ-023 REQ: mem_command=BUS_LOAD, mem_addr=head; mem_response!=0 -> latch tag, WAIT; 0 -> stay REQ, re-issue.
REQ-024 WAIT: mem_command=BUS_NONE; mem_tag==latched tag -> latch mem_data, FILL; other tags ignored.
REQ-025 FILL: fill_en=1 exactly one cycle, fill_addr=head, fill_data=latched data; pop head; next REQ if entries remain after pop, else IDLE.
REQ-026 Miss matching the head during FILL SHALL coalesce (cache is written the same edge).
REQ-027 Only one memory transaction SHALL be outstanding; latency miss_valid (cycle t, empty, IDLE) -> first BUS_LOAD SHALL be t+2.
REQ-028 Latched tag SHALL be 0 whenever state is not WAIT, so mem_tag=0 never matches.

Reset
REQ-029 Reset SHALL empty the queue, set IDLE, clear latched tag/data.
REQ-030 Reset values: miss_ready=1, mem_command=BUS_NONE, mem_addr=0, fill_en=0, fill_addr=0, fill_data=0, busy=0.
REQ-031 Reset mid-transaction SHALL drop it; a late mem_tag for the old tag SHALL produce no fill.

Configuration
REQ-032 Macro DCACHE_MISS_FAST_FILL_EN defined: FILL state removed; on WAIT tag match, fill_en=1 same cycle, fill_data=mem_data, pop, next REQ/IDLE per REQ-025.
REQ-033 Macro undefined: behaviour per REQ-024/025 (fill one cycle after tag match).

Verification
REQ-034 Reset, miss 0x1008 at t; mem_response=3 at t+2; mem_tag=3, mem_data=0xDEADBEEF_CAFEF00D at t+6 -> BUS_LOAD 0x1008 at t+2 only; fill_en at t+7 (t+6 with macro), data matches, busy 0 after.
REQ-035 mem_response=0 for 3 cycles then 5 -> BUS_LOAD held 4 cycles at same address; one fill.
REQ-036 Misses 0x2000, 0x2004, 0x2000 -> one entry, one BUS_LOAD, one fill at 0x2000.
REQ-037 Five distinct misses, MSHR_DEPTH=4, memory stalled -> 5th sees miss_ready=0; fills in issue order after release.
REQ-038 In WAIT with tag 2, mem_tag=7 then 2 -> no fill on 7, fill on 2.
REQ-039 Reset in WAIT (tag 4), then mem_tag=4 -> fill_en stays 0, state IDLE, miss_ready=1.
